// File: rtl/irs_sample_sequencer.sv
// Reads one channel window of NUM_SAMPLES samples: address load or increment, wait for the
// address, settle, latch. Any request left unanswered for TIMEOUT_CYCLES enabled cycles aborts the window.
module irs_sample_sequencer #(
  parameter int NUM_SAMPLES    = 64,
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en,
  input  logic        start_i,
  input  logic [2:0]  sel_channel_i,
  output logic        ro_start_o,
  output logic        ro_increment_o,
  input  logic        ro_reached_i,
  input  logic [11:0] irs_dat_i,
  output logic        irs_smpall_o,
  output logic [11:0] dat_o,
  output logic [5:0]  smp_o,
  output logic [2:0]  ch_o,
  output logic        valid_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, SETTLE, LATCH, INC_REQ, INC_WAIT, ABORT
  } state_t;

  localparam logic [5:0] LAST_SMP    = 6'(NUM_SAMPLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [7:0] TO_LAST     = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [5:0] sample_cnt;
  logic [7:0] tmr;
  logic [2:0] chan;

  always_ff @(posedge clk_i) begin
    // valid_o/done_o are single clk_i pulses even when clk_en is low
    valid_o <= 1'b0;
    done_o  <= 1'b0;
    if (rst_i) begin
      state          <= IDLE;
      sample_cnt     <= 6'd0;
      tmr            <= 8'd0;
      chan           <= 3'd0;
      ro_start_o     <= 1'b0;
      ro_increment_o <= 1'b0;
      irs_smpall_o   <= 1'b0;
      dat_o          <= 12'd0;
      smp_o          <= 6'd0;
      ch_o           <= 3'd0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            chan           <= sel_channel_i;
            sample_cnt     <= 6'd0;
            err_o          <= 1'b0;
            ro_start_o     <= 1'b1;
            ro_increment_o <= 1'b1;
            busy_o         <= 1'b1;
            state          <= LOAD_REQ;
          end
        end
        LOAD_REQ, INC_REQ: begin
          ro_start_o     <= 1'b0;
          ro_increment_o <= 1'b0;
          // the request cycle itself counts toward the timeout
          tmr            <= 8'd1;
          state          <= (state == LOAD_REQ) ? LOAD_WAIT : INC_WAIT;
        end
        LOAD_WAIT, INC_WAIT: begin
          if (ro_reached_i) begin
            tmr          <= 8'd0;
            irs_smpall_o <= 1'b1;
            if (state == INC_WAIT) sample_cnt <= sample_cnt + 6'd1;
            state        <= SETTLE;
          end else if (tmr >= TO_LAST) begin
            err_o <= 1'b1;
            state <= ABORT;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        SETTLE: begin
          if (tmr >= SETTLE_LAST) state <= LATCH;
          else tmr <= tmr + 8'd1;
        end
        LATCH: begin
          dat_o        <= irs_dat_i;
          smp_o        <= sample_cnt;
          ch_o         <= chan;
          valid_o      <= 1'b1;
          irs_smpall_o <= 1'b0;
          if (sample_cnt == LAST_SMP) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            ro_start_o <= 1'b1;
            state      <= INC_REQ;
          end
        end
        ABORT: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irs_sample_sequencer.sv
// Directed bench: a responder model answers address requests and drives sample data;
// the main DUT runs a 64-sample window and a second instance runs a single-sample window.
module tb_irs_sample_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i, clk_en, start_i, ro_reached_i;
  logic [2:0]  sel_channel_i;
  logic [11:0] irs_dat_i;
  logic        ro_start_o, ro_increment_o, irs_smpall_o, valid_o, done_o, busy_o, err_o;
  logic [11:0] dat_o;
  logic [5:0]  smp_o;
  logic [2:0]  ch_o;

  logic        start1, reached1;
  logic        ro_start_1, ro_inc_1, smpall_1, valid_1, done_1, busy_1, err_1;
  logic [11:0] dat_1;
  logic [5:0]  smp_1;
  logic [2:0]  ch_1;

  irs_sample_sequencer u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en(clk_en), .start_i(start_i),
    .sel_channel_i(sel_channel_i), .ro_start_o(ro_start_o), .ro_increment_o(ro_increment_o),
    .ro_reached_i(ro_reached_i), .irs_dat_i(irs_dat_i), .irs_smpall_o(irs_smpall_o),
    .dat_o(dat_o), .smp_o(smp_o), .ch_o(ch_o), .valid_o(valid_o), .done_o(done_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  irs_sample_sequencer #(.NUM_SAMPLES(1), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(255)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .clk_en(clk_en), .start_i(start1),
    .sel_channel_i(sel_channel_i), .ro_start_o(ro_start_1), .ro_increment_o(ro_inc_1),
    .ro_reached_i(reached1), .irs_dat_i(irs_dat_i), .irs_smpall_o(smpall_1),
    .dat_o(dat_1), .smp_o(smp_1), .ch_o(ch_1), .valid_o(valid_1), .done_o(done_1),
    .busy_o(busy_1), .err_o(err_1)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  int cyc = 0;
  int loads, incs, vcnt, dcnt, cd, addr, no_answer, req_cyc, err_cyc, rs_len, req_len_exp;
  int loads1, incs1, v1, d1, cd1;
  logic [2:0] exp_ch;
  logic rs_prev, rs1_prev, v_prev, err_prev, en3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    loads = 0; incs = 0; vcnt = 0; dcnt = 0; cd = 0; addr = 0;
    loads1 = 0; incs1 = 0; v1 = 0; d1 = 0; cd1 = 0;
  endtask

  // One clk_i cycle; the responder model and the output monitors run here.
  task automatic tick();
    logic en_was;
    en_was = clk_en;
    @(posedge clk_i); #1;
    cyc++;
    if (ro_reached_i && en_was) ro_reached_i = 1'b0;
    if (reached1 && en_was) reached1 = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin ro_reached_i = 1'b1; irs_dat_i = 12'(addr); end
    end
    if (cd1 > 0) begin
      cd1--;
      if (cd1 == 0) reached1 = 1'b1;
    end
    if (ro_start_o && !rs_prev) begin
      if (ro_increment_o) begin
        loads++; addr = 0; cd = 4;
      end else begin
        incs++; addr++;
        if (incs == no_answer) req_cyc = cyc;
        else cd = 4;
      end
    end
    if (ro_start_o) rs_len++;
    else if (rs_prev) begin
      chk("req_len", rs_len, req_len_exp);
      rs_len = 0;
    end
    if (ro_start_1 && !rs1_prev) begin
      if (ro_inc_1) loads1++; else incs1++;
      cd1 = 2;
    end
    if (valid_o) begin
      chk("smp", smp_o, vcnt);
      chk("dat", dat_o, vcnt);
      chk("ch", ch_o, exp_ch);
      chk("done_last", done_o, (vcnt == 63) ? 1 : 0);
      chk("valid_pulse", v_prev, 0);
      vcnt++;
    end
    if (done_o) begin
      chk("done_with_valid", valid_o, 1);
      dcnt++;
    end
    if (valid_1) begin
      chk("d1_smp", smp_1, 0);
      chk("d1_done", done_1, 1);
      v1++;
    end
    if (done_1) d1++;
    if (err_o && !err_prev) err_cyc = cyc;
    rs_prev = ro_start_o; rs1_prev = ro_start_1; v_prev = valid_o; err_prev = err_o;
    clk_en = en3 ? ((cyc % 3) == 0) : 1'b1;
  endtask

  task automatic do_start(input logic [2:0] ch);
    sel_channel_i = ch;
    start_i = 1'b1;
    for (int g = 0; g < 20 && !busy_o; g++) tick();
    start_i = 1'b0;
    chk("start_busy", busy_o, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int g = 0; g < budget && dcnt == 0; g++) tick();
    chk("window_done", dcnt, 1);
  endtask

  initial begin
    rst_i = 1'b1; clk_en = 1'b1; start_i = 1'b0; ro_reached_i = 1'b0; sel_channel_i = 3'd0;
    irs_dat_i = 12'd0; start1 = 1'b0; reached1 = 1'b0;
    rs_prev = 1'b0; rs1_prev = 1'b0; v_prev = 1'b0; err_prev = 1'b0; en3 = 1'b0;
    no_answer = 0; req_cyc = 0; err_cyc = 0; rs_len = 0; req_len_exp = 1; exp_ch = 3'd0;
    clear_stats();
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_outputs", {ro_start_o, ro_increment_o, irs_smpall_o, valid_o, done_o, busy_o, err_o}, 0);
    chk("rst_data", {dat_o, smp_o, ch_o}, 0);

    // Nominal window on channel 5
    exp_ch = 3'd5;
    do_start(3'd5);
    wait_done(3000);
    chk("nom_valids", vcnt, 64);
    chk("nom_loads", loads, 1);
    chk("nom_incs", incs, 63);
    chk("nom_busy", busy_o, 0);
    chk("nom_err", err_o, 0);

    // 10th increment never answered
    clear_stats(); no_answer = 10;
    do_start(3'd5);
    for (int g = 0; g < 3000 && !err_o; g++) tick();
    chk("to_err", err_o, 1);
    chk("to_delay", err_cyc - req_cyc, 255);
    chk("to_abort_busy", busy_o, 1);
    tick(); tick();
    chk("to_idle_busy", busy_o, 0);
    chk("to_valids", vcnt, 10);
    chk("to_dones", dcnt, 0);
    no_answer = 0;

    // Clock enable every third cycle
    clear_stats(); en3 = 1'b1; req_len_exp = 3;
    do_start(3'd5);
    chk("en3_err_cleared", err_o, 0);
    wait_done(8000);
    chk("en3_valids", vcnt, 64);
    chk("en3_incs", incs, 63);
    chk("en3_err", err_o, 0);
    en3 = 1'b0; req_len_exp = 1;
    for (int g = 0; g < 4; g++) tick();

    // Reset after the 20th sample
    clear_stats();
    do_start(3'd5);
    for (int g = 0; g < 3000 && vcnt < 20; g++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; cd = 0; ro_reached_i = 1'b0;
    chk("mid_rst_outputs", {ro_start_o, ro_increment_o, irs_smpall_o, valid_o, done_o, busy_o, err_o}, 0);
    chk("mid_rst_data", {dat_o, smp_o, ch_o}, 0);
    clear_stats();
    for (int g = 0; g < 10; g++) tick();
    chk("mid_rst_quiet", loads + incs + vcnt, 0);
    exp_ch = 3'd2;
    do_start(3'd2);
    wait_done(3000);
    chk("rst_new_valids", vcnt, 64);

    // start_i held high with sel_channel_i toggling
    clear_stats(); exp_ch = 3'd6;
    sel_channel_i = 3'd6; start_i = 1'b1;
    for (int g = 0; g < 20 && !busy_o; g++) tick();
    for (int g = 0; g < 3000 && dcnt == 0; g++) begin
      sel_channel_i = sel_channel_i ^ 3'd7;
      tick();
    end
    chk("hold_done", dcnt, 1);
    chk("hold_valids", vcnt, 64);
    chk("hold_idle", busy_o, 0);
    chk("hold_one_window", loads, 1);
    tick();
    chk("hold_second_window", loads, 2);
    start_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; cd = 0; ro_reached_i = 1'b0;
    tick();

    // Single-sample instance, no settle cycles
    clear_stats();
    start1 = 1'b1;
    for (int g = 0; g < 20 && !busy_1; g++) tick();
    start1 = 1'b0;
    for (int g = 0; g < 500 && v1 == 0; g++) tick();
    tick(); tick();
    chk("d1_loads", loads1, 1);
    chk("d1_incs", incs1, 0);
    chk("d1_valids", v1, 1);
    chk("d1_dones", d1, 1);
    chk("d1_busy", busy_1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irs_sample_sequencer.md
IRS_SAMPLE_SEQUENCER -- requirements
Module: irs_sample_sequencer

Interface
REQ-001 Parameter NUM_SAMPLES, default 64: samples read per channel window; legal range 1..64.
REQ-002 Parameter SETTLE_CYCLES, default 3: enabled cycles between address reached and data latch; legal range 0..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: enabled cycles allowed for ro_reached_i after a request; legal range 1..255.
REQ-004 clk_i  in  1  system clock; single clock domain.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 clk_en  in  1  clock enable; FSM, counters and registers advance only when high.
REQ-007 start_i  in  1  begin readout of one channel window.
REQ-008 sel_channel_i  in  3  channel to read; captured at start.
REQ-009 ro_start_o  out  1  request to the serial address controller.
REQ-010 ro_increment_o  out  1  request type: 1 = serial address load, 0 = single address increment.
REQ-011 ro_reached_i  in  1  controller pulse: requested address is now valid.
REQ-012 irs_dat_i  in  12  ASIC sample data bus.
REQ-013 irs_smpall_o  out  1  ASIC data output enable.
REQ-014 dat_o  out  12  latched sample.
REQ-015 smp_o  out  6  sample index of dat_o.
REQ-016 ch_o  out  3  channel of dat_o.
REQ-017 valid_o  out  1  dat_o/smp_o/ch_o valid, one clk_i cycle per sample.
REQ-018 done_o  out  1  one-cycle pulse together with the valid_o of the last sample.
REQ-019 busy_o  out  1  high in every state except IDLE.
REQ-020 err_o  out  1  sticky timeout flag.

Function
REQ-021 States: IDLE, LOAD_REQ, LOAD_WAIT, SETTLE, LATCH, INC_REQ, INC_WAIT, ABORT.
REQ-022 IDLE: on start_i with clk_en high, capture sel_channel_i, clear sample_cnt, clear err_o, and go to LOAD_REQ; start_i is ignored in all other states.
REQ-023 LOAD_REQ: assert ro_start_o=1 and ro_increment_o=1 for exactly one enabled cycle, then go to LOAD_WAIT.
REQ-024 INC_REQ: assert ro_start_o=1 and ro_increment_o=0 for exactly one enabled cycle, then go to INC_WAIT.
REQ-025 LOAD_WAIT/INC_WAIT: on ro_reached_i go to SETTLE and clear the timeout counter; INC_WAIT additionally increments sample_cnt.
REQ-026 SETTLE: count SETTLE_CYCLES enabled cycles, then go to LATCH; when SETTLE_CYCLES=0, SETTLE lasts one cycle.
REQ-027 LATCH: register dat_o<=irs_dat_i, smp_o<=sample_cnt, ch_o<=captured channel, and pulse valid_o the following clk_i cycle.
REQ-028 LATCH exit: if sample_cnt==NUM_SAMPLES-1, pulse done_o with that valid_o and go to IDLE; otherwise go to INC_REQ.
REQ-029 irs_smpall_o is high in SETTLE and LATCH only.
REQ-030 sample_cnt is 6 bits and never wraps within a window; the NUM_SAMPLES bound ends the window first.
REQ-031 Timeout: in LOAD_WAIT or INC_WAIT, if TIMEOUT_CYCLES enabled cycles elapse without ro_reached_i, set err_o, go to ABORT, and issue no valid_o and no done_o.
REQ-032 ABORT lasts one enabled cycle, then goes to IDLE.
REQ-033 ro_reached_i outside LOAD_WAIT/INC_WAIT is ignored.
REQ-034 ro_reached_i on the same cycle as timeout expiry counts as reached: no error.
REQ-035 With clk_en low, all state, outputs and counters hold, except valid_o and done_o, which are never held more than one clk_i cycle.
REQ-036 Changes to sel_channel_i during a window have no effect until the next start.

Reset
REQ-037 rst_i high at a clk_i edge with clk_en high forces IDLE; rst_i with clk_en low also forces IDLE.
REQ-038 Reset clears sample_cnt, the timeout counter and all outputs to 0 (dat_o=0, smp_o=0, ch_o=0, err_o=0).
REQ-039 Reset mid-window aborts immediately: no further ro_start_o, valid_o or done_o.

Verification
REQ-040 Nominal: clk_en=1, ch=5, model returns ro_reached_i 4 cycles after each request, irs_dat_i=sample index -> 64 valid_o with smp_o 0..63, ch_o=5, dat_o=smp_o, done_o only with smp_o=63, exactly 1 load and 63 increment requests.
REQ-041 Timeout: model never answers the 10th increment -> err_o=1 exactly 255 cycles after that request, valid_o count=10, no done_o, busy_o low 2 cycles later.
REQ-042 clk_en=1 every third cycle, nominal model -> same data sequence as REQ-040, each request pulse lasting one enabled period.
REQ-043 rst_i asserted after the 20th valid_o -> all outputs 0 next cycle; a new start_i with ch=2 yields a full window of 64 samples with ch_o=2.
REQ-044 start_i held high throughout a window and sel_channel_i toggled -> a single window, ch_o constant; a second window starts only after return to IDLE.
REQ-045 NUM_SAMPLES=1, SETTLE_CYCLES=0 -> one load, zero increments, a single valid_o with done_o.
